// File: rtl/inst_sram_axi_bridge.sv
// rtl/inst_sram_axi_bridge.sv - sram-like instruction fetch port to single-beat AXI4 read bridge
//
// Purpose: accepts one sram-like fetch request at a time and turns each read into a
// single-beat AXI4 read (AR then R). Writes are acknowledged locally without bus traffic.
//
// Optional feature macro: INST_BRIDGE_RRESP_CHECK_EN
//   defined   -> inst_bus_err port exists and flags a non-OKAY rresp alongside inst_data_ok
//   undefined -> inst_bus_err port absent, rresp ignored
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   inst_req/wr/size/addr/uncached   fetch request (sampled only when inst_addr_ok=1)
//   inst_addr_ok             combinational accept
//   inst_data_ok, inst_rdata registered one-cycle response pulse and held read data
//   inst_bus_err             response error flag (feature macro only)
//   ar*                      AXI read address channel (single beat, fixed ID)
//   r*                       AXI read data channel

module inst_sram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic        inst_uncached,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
`ifdef INST_BRIDGE_RRESP_CHECK_EN
  output logic        inst_bus_err,
`endif
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [3:0]  arcache,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_uncached;
  logic        req_wr;

  // Accept only in IDLE; gating with rst keeps the fetch stage from seeing an
  // accept while the bridge is being held in reset.
  assign inst_addr_ok = (state == ST_IDLE) & inst_req & rst;

  assign arid    = AXI_ID;
  assign araddr  = req_addr;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, req_size};
  assign arcache = req_uncached ? 4'b0000 : 4'b1111;

`ifdef INST_BRIDGE_RRESP_CHECK_EN
  logic resp_err;
  assign inst_bus_err = inst_data_ok & resp_err;
  logic unused_ok;
  assign unused_ok = &{1'b0, req_wr};
`else
  // rresp is deliberately ignored in this build.
  logic unused_ok;
  assign unused_ok = &{1'b0, req_wr, rresp};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      inst_data_ok <= 1'b0;
      inst_rdata   <= 32'd0;
      req_addr     <= 32'd0;
      req_size     <= 2'd0;
      req_uncached <= 1'b0;
      req_wr       <= 1'b0;
`ifdef INST_BRIDGE_RRESP_CHECK_EN
      resp_err     <= 1'b0;
`endif
    end else begin
      // data_ok is a single-cycle pulse unless re-raised below.
      inst_data_ok <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (inst_addr_ok) begin
            req_addr     <= inst_addr;
            req_size     <= inst_size;
            req_uncached <= inst_uncached;
            req_wr       <= inst_wr;
            if (inst_wr) begin
              // Writes are not routed to AXI; acknowledge and keep old rdata.
              inst_data_ok <= 1'b1;
`ifdef INST_BRIDGE_RRESP_CHECK_EN
              resp_err     <= 1'b0;
`endif
            end else begin
              state   <= ST_AR;
              arvalid <= 1'b1;
            end
          end
        end
        ST_AR: begin
          // arvalid and the address fields hold until the handshake.
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_R;
          end
        end
        ST_R: begin
          // arlen=0, so the first beat is the only beat; rlast is not needed.
          if (rvalid) begin
            rready       <= 1'b0;
            inst_rdata   <= rdata;
            inst_data_ok <= 1'b1;
            state        <= ST_IDLE;
`ifdef INST_BRIDGE_RRESP_CHECK_EN
            resp_err     <= (rresp != 2'b00);
`endif
          end
        end
        default: begin
          state   <= ST_IDLE;
          arvalid <= 1'b0;
          rready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// tb/tb_inst_sram_axi_bridge.sv - directed table-driven bench for inst_sram_axi_bridge

module tb_inst_sram_axi_bridge;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_uncached;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
`ifdef INST_BRIDGE_RRESP_CHECK_EN
  logic        inst_bus_err;
`endif
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [3:0]  arcache;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int tests;
  int failed;

  inst_sram_axi_bridge #(.AXI_ID(4'd0)) dut (
    .clk(clk),
    .rst(rst),
    .inst_req(inst_req),
    .inst_wr(inst_wr),
    .inst_size(inst_size),
    .inst_addr(inst_addr),
    .inst_uncached(inst_uncached),
    .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
`ifdef INST_BRIDGE_RRESP_CHECK_EN
    .inst_bus_err(inst_bus_err),
`endif
    .arid(arid),
    .araddr(araddr),
    .arlen(arlen),
    .arsize(arsize),
    .arcache(arcache),
    .arvalid(arvalid),
    .arready(arready),
    .rdata(rdata),
    .rresp(rresp),
    .rvalid(rvalid),
    .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        unc;
    int          ar_dly;
    int          r_dly;
    logic [31:0] rd;
    logic [1:0]  resp;
    logic        noise;
    logic [2:0]  exp_arsize;
    logic [3:0]  exp_arcache;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  vec_t vecs[4];
  vec_t b0, b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a read request in the current (post-negedge) window and check it is accepted.
  task automatic issue(input vec_t v);
    inst_req      = 1'b1;
    inst_wr       = 1'b0;
    inst_addr     = v.addr;
    inst_size     = v.size;
    inst_uncached = v.unc;
    arready       = 1'b0;
    rvalid        = 1'b0;
    #1;
    chk("addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("rready_idle", {31'd0, rready}, 32'd0);
  endtask

  // Play the AXI responder for one accepted read; returns in the data_ok cycle.
  task automatic finish(input vec_t v);
    int   lat;
    int   n;
    int   m;
    logic stable;
    lat = 0;
    stable = 1'b1;
    @(negedge clk);
    lat++;
    // Optional noise: keep a different request pending while busy.
    inst_req  = v.noise;
    inst_addr = 32'hDEAD0000;
    n = 0;
    while (1) begin
      #1;
      if (!arvalid || araddr !== v.addr || arsize !== v.exp_arsize ||
          arcache !== v.exp_arcache || arid !== 4'd0 || arlen !== 8'd0 ||
          rready || inst_addr_ok || inst_data_ok)
        stable = 1'b0;
      if (n >= v.ar_dly) arready = 1'b1;
      @(negedge clk);
      lat++;
      n++;
      if (arready) begin
        arready = 1'b0;
        break;
      end
      if (n > 40) begin
        chk("ar_timeout", 32'd1, 32'd0);
        inst_req = 1'b0;
        return;
      end
    end
    chk("ar_stable", {31'd0, stable}, 32'd1);
    chk("ar_cycles", n, v.ar_dly + 1);
    stable = 1'b1;
    m = 0;
    while (1) begin
      #1;
      if (!rready || arvalid || inst_addr_ok || inst_data_ok) stable = 1'b0;
      if (m >= v.r_dly) begin
        rvalid   = 1'b1;
        rdata    = v.rd;
        rresp    = v.resp;
        inst_req = 1'b0;
      end else begin
        rdata = 32'h0BAD0BAD;
        rresp = 2'b01;
      end
      @(negedge clk);
      lat++;
      m++;
      if (rvalid) begin
        rvalid = 1'b0;
        break;
      end
      if (m > 40) begin
        chk("r_timeout", 32'd1, 32'd0);
        inst_req = 1'b0;
        return;
      end
    end
    #1;
    chk("r_stable", {31'd0, stable}, 32'd1);
    chk("data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("inst_rdata", inst_rdata, v.rd);
    chk("latency", lat, v.exp_lat);
    chk("rready_after", {31'd0, rready}, 32'd0);
`ifdef INST_BRIDGE_RRESP_CHECK_EN
    chk("bus_err", {31'd0, inst_bus_err}, {31'd0, v.exp_err});
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    failed = 0;
    //          addr          sz   unc  ard rd  rdata          resp   noise arsize arcache lat err
    vecs[0] = '{32'hBFC00000, 2'd2, 1'b1, 0, 0, 32'h3C08BFC0, 2'b00, 1'b0, 3'd2, 4'h0, 3,  1'b0};
    vecs[1] = '{32'h80000010, 2'd1, 1'b0, 5, 3, 32'h12345678, 2'b00, 1'b1, 3'd1, 4'hF, 11, 1'b0};
    vecs[2] = '{32'h90000003, 2'd0, 1'b1, 2, 1, 32'hA5A55A5A, 2'b10, 1'b0, 3'd0, 4'h0, 6,  1'b1};
    vecs[3] = '{32'h00000040, 2'd2, 1'b0, 0, 4, 32'hFFFF0000, 2'b11, 1'b1, 3'd2, 4'hF, 7,  1'b1};
    b0      = '{32'h80000000, 2'd2, 1'b0, 0, 0, 32'h11111111, 2'b00, 1'b0, 3'd2, 4'hF, 3,  1'b0};
    b1      = '{32'h80000004, 2'd2, 1'b0, 0, 0, 32'h22222222, 2'b00, 1'b0, 3'd2, 4'hF, 3,  1'b0};

    // Reset with a request pending: nothing may be accepted.
    rst = 1'b0;
    inst_req = 1'b1;
    inst_wr = 1'b0;
    inst_size = 2'd2;
    inst_addr = 32'h00001000;
    inst_uncached = 1'b0;
    arready = 1'b0;
    rvalid = 1'b0;
    rdata = 32'd0;
    rresp = 2'b00;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("rst_rdata", inst_rdata, 32'd0);
    rst = 1'b1;
    inst_req = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      issue(vecs[i]);
      finish(vecs[i]);
      @(negedge clk);
      #1;
      chk("data_ok_pulse", {31'd0, inst_data_ok}, 32'd0);
      chk("rdata_held", inst_rdata, vecs[i].rd);
    end

    // Back-to-back: second accept lands in the first data_ok cycle.
    issue(b0);
    finish(b0);
    issue(b1);
    chk("b2b_data_ok", {31'd0, inst_data_ok}, 32'd1);
    finish(b1);
    @(negedge clk);

    // Write: local acknowledge, no AXI traffic, rdata unchanged.
    inst_req = 1'b1;
    inst_wr = 1'b1;
    inst_addr = 32'h00001234;
    #1;
    chk("wr_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    @(negedge clk);
    inst_req = 1'b0;
    inst_wr = 1'b0;
    #1;
    chk("wr_arvalid", {31'd0, arvalid}, 32'd0);
    chk("wr_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("wr_rdata", inst_rdata, 32'h22222222);
`ifdef INST_BRIDGE_RRESP_CHECK_EN
    chk("wr_bus_err", {31'd0, inst_bus_err}, 32'd0);
`endif
    @(negedge clk);
    #1;
    chk("wr_pulse", {31'd0, inst_data_ok}, 32'd0);
    chk("wr_no_ar", {31'd0, arvalid}, 32'd0);

    // Reset in the middle of a read: abandon it, then accept a fresh one.
    @(negedge clk);
    issue(vecs[0]);
    @(negedge clk);
    inst_req = 1'b0;
    #1;
    chk("mid_arvalid_pre", {31'd0, arvalid}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_arvalid", {31'd0, arvalid}, 32'd0);
    chk("mid_rready", {31'd0, rready}, 32'd0);
    chk("mid_rdata", inst_rdata, 32'd0);
    chk("mid_data_ok", {31'd0, inst_data_ok}, 32'd0);
    rst = 1'b1;
    issue(vecs[0]);
    finish(vecs[0]);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
